mips32_fetch_queue: RTL
=======================

# mips32_fetch_queue

Instruction-fetch front end for the MIPS32 pipeline. It issues word-addressed reads to instruction memory, buffers the returned words in a DEPTH-entry prefetch queue, and presents {IR, NPC} pairs to the IF/ID register over a valid/ready handshake. It also absorbs taken-branch redirects from the EX/MEM stage: the queue is flushed, stale in-flight memory responses are discarded, and fetch restarts at the target. HALT stops further fetching.

## Interface
- DEPTH, 4: prefetch queue entries and the maximum of queued plus in-flight fetches. Power of two, at least 2.
- RESET_PC, 0: word address of the first fetch after reset.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request. Combinational: !halted && !redirect && (q_count + inflight < DEPTH).
- imem_addr  out  32  word address of the request; equals PC.
- imem_gnt  in  1  memory accepts the request this cycle; only meaningful while imem_req=1.
- imem_rvalid  in  1  read data valid. Responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch; one-cycle pulse.
- redirect_pc  in  32  branch target word address.
- halt  in  1  HLT decoded; sets a sticky halted flag.
- id_valid  out  1  queue head is valid (q_count != 0).
- id_ready  in  1  IF/ID consumes the head this cycle.
- id_ir  out  32  head instruction word.
- id_npc  out  32  head instruction address + 1.
- halted  out  1  sticky halt status.

## Operation
- State:
  - PC: next fetch address.
  - resp_pc: address of the next non-stale response.
  - FIFO of {ir, npc} with wr_ptr, rd_ptr and q_count.
  - inflight: granted requests not yet responded to, 0..DEPTH.
  - stale: how many of those in-flight responses must be dropped.
  - halted flag.
- Grant (imem_req && imem_gnt): PC <= PC+1 and inflight increments.
- Response (imem_rvalid):
  - inflight decrements.
  - If stale > 0, the word is dropped and stale decrements.
  - Otherwise the FIFO pushes {imem_rdata, resp_pc+1} and resp_pc increments.
- Pop (id_valid && id_ready): rd_ptr advances. A push and a pop in the same cycle leave q_count unchanged.
- Redirect has priority over every other update in its cycle:
  - FIFO flushed: q_count=0 and pointers reset.
  - PC <= redirect_pc and resp_pc <= redirect_pc.
  - stale <= inflight minus 1 if a response arrives this cycle (that response is itself dropped).
  - No request is issued in the redirect cycle.
  - Any pop in that cycle is still accepted by the consumer but has no further effect.
- Halt: halted <= 1 and stays set until rst.
  - While halted, imem_req=0.
  - In-flight responses are still accepted and pushed.
  - The queue keeps draining.
  - A redirect while halted still flushes the queue and updates PC but issues nothing.
- Credit rule: q_count + inflight <= DEPTH always, so a push never overflows. A push when full is a design error; flag it in assertions.
- imem_rvalid while inflight == 0 is a protocol error. Ignore it: no state change, and an assertion fires.
- Arithmetic: addresses are 32-bit and wrap modulo 2^32 (0xFFFFFFFF+1 = 0). Counters are clog2(DEPTH)+1 bits.

## Timing
- Reset (async assert, sync release):
  - PC = resp_pc = RESET_PC.
  - q_count = inflight = stale = 0.
  - halted = 0.
  - id_valid = 0, id_ir = 0, id_npc = 0.
  - imem_req = 0 while rst is high.
- First request: imem_req=1 with imem_addr=RESET_PC in the first cycle after rst deasserts.
- Latency: grant in cycle N, response in cycle N+1 (minimum), id_valid=1 with that word in cycle N+2.
- Throughput: 1 instruction/cycle sustained when imem_gnt=1, memory latency is 1 and id_ready=1.
- Outputs: id_ir and id_npc come from the FIFO head registers and are stable while id_valid=1 && id_ready=0.
- Redirect in cycle R:
  - id_valid=0 in R+1.
  - imem_req=1 with imem_addr=redirect_pc in R+1.
  - First target instruction at id_valid no earlier than R+3.
- Halt in cycle H: imem_req=0 from H+1 onward.

## Test plan
- Reset then free-run: memory returns word = 0x1000+addr with 1-cycle latency, id_ready=1 -> id_{ir,npc} = (0x1000,1), (0x1001,2), ... on consecutive cycles starting 2 cycles after the first grant.
- Backpressure: id_ready=0 for 10 cycles -> exactly DEPTH=4 words queued, imem_req=0 afterwards, no loss; on release, addresses 0..3 drain in order.
- Redirect with 2 in flight (memory latency 3): redirect_pc=0x40 -> both stale words dropped, next id_valid shows (mem[0x40], 0x41), queue empty in between.
- Redirect coincident with a response and a pop -> that response dropped, stale = inflight-1, no stale word ever reaches the ID side.
- Halt after fetching address 5 while addresses 6 and 7 are in flight -> 6 and 7 still delivered, no request for address 8, halted=1 until rst.
- Async rst asserted mid-stream with 3 queued and 2 in flight -> all outputs return to reset values immediately; after release, fetch restarts at RESET_PC and late responses are ignored per the inflight==0 rule.

Source files
------------

// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: instruction prefetch queue with branch redirect and halt
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_npc,
  output logic        halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc, resp_pc;
  logic [31:0]   fifo_ir  [DEPTH];
  logic [31:0]   fifo_npc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_count, inflight, stale;
  logic          gnt, rv, push, pop;
  // Credit-limited request plus handshake qualifiers; a response with nothing in flight is ignored
  always_comb begin
    imem_req  = !rst && !halted && !redirect && ({1'b0, q_count} + {1'b0, inflight} < (CW+1)'(DEPTH));
    imem_addr = pc;
    gnt       = imem_req && imem_gnt;
    rv        = imem_rvalid && (inflight != '0);
    push      = rv && (stale == '0);
    id_valid  = q_count != '0;
    pop       = id_valid && id_ready;
    id_ir     = fifo_ir[rd_ptr];
    id_npc    = fifo_npc[rd_ptr];
  end
  // Fetch, queue and in-flight bookkeeping; a redirect flushes and marks remaining responses stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      inflight <= '0;
      stale    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_ir[i]  <= '0;
        fifo_npc[i] <= '0;
      end
    end else if (redirect) begin
      pc       <= redirect_pc;
      resp_pc  <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      inflight <= inflight - CW'(rv);
      stale    <= inflight - CW'(rv);
    end else begin
      if (gnt) pc <= pc + 32'd1;
      if (push) begin
        fifo_ir[wr_ptr]  <= imem_rdata;
        fifo_npc[wr_ptr] <= resp_pc + 32'd1;
        wr_ptr           <= wr_ptr + AW'(1);
        resp_pc          <= resp_pc + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (rv && stale != '0) stale <= stale - CW'(1);
      q_count  <= q_count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(gnt) - CW'(rv);
    end
  end
  // Sticky halt until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else if (halt) halted <= 1'b1;
  end
  assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && inflight == '0));
  assert property (@(posedge clk) disable iff (rst) !(push && !redirect && q_count == CW'(DEPTH)));
endmodule
